// File: rtl/tiny45_instr_fetch.sv
// Instruction fetch/prefetch: streams halfwords from a sequential memory port into a
// 4-entry buffer and presents assembled 16/32-bit instructions with their PC.
module tiny45_instr_fetch #(
    parameter int                   ADDR_BITS = 24,
    parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_start,
    output logic                 mem_stop,
    input  logic [15:0]          mem_data_in,
    input  logic                 mem_data_valid,
    output logic                 mem_data_ready,
    output logic [31:0]          instr,
    output logic [ADDR_BITS-1:0] pc,
    output logic                 instr_valid,
    input  logic                 instr_complete,
    input  logic                 branch,
    input  logic [ADDR_BITS-1:0] branch_target
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

    logic [1:0]           state_reg, state_next;
    logic [ADDR_BITS-1:0] pc_reg, pc_next;
    logic [ADDR_BITS-1:0] mem_addr_reg;
    logic [ADDR_BITS-1:0] fetch_addr_next;
    logic [2:0]           count_reg, count_next;
    logic                 mem_start_reg, mem_stop_reg;

    logic [15:0] fifo [4];
    logic        is_long;
    logic        push;
    logic [2:0]  pop_n;
    logic [2:0]  tail;

    assign is_long        = (fifo[0][1:0] == 2'b11);
    assign instr_valid    = is_long ? (count_reg >= 3'd2) : (count_reg >= 3'd1);
    assign mem_data_ready = (state_reg == S_STREAM) && (count_reg < 3'd4) && !branch;
    assign push           = mem_data_valid && mem_data_ready;
    assign pop_n          = (instr_complete && instr_valid && !branch)
                            ? (is_long ? 3'd2 : 3'd1) : 3'd0;
    // Pushed halfword lands just behind whatever survives this cycle's pop.
    assign tail           = count_reg - pop_n;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_entry
            logic [15:0] entry_reg, entry_next;
            logic [15:0] shift1, shift2;

            if (gi < 3) begin : g_s1
                assign shift1 = fifo[gi+1];
            end else begin : g_s1_edge
                assign shift1 = entry_reg;
            end

            if (gi < 2) begin : g_s2
                assign shift2 = fifo[gi+2];
            end else begin : g_s2_edge
                assign shift2 = entry_reg;
            end

            always_comb begin
                entry_next = entry_reg;
                case (pop_n)
                    3'd1:    entry_next = shift1;
                    3'd2:    entry_next = shift2;
                    default: entry_next = entry_reg;
                endcase
                if (push && (tail == 3'(gi))) begin
                    entry_next = mem_data_in;
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    entry_reg <= '0;
                end else if (!branch) begin
                    entry_reg <= entry_next;
                end
            end

            assign fifo[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        if (branch) begin
            pc_next    = branch_target & ALIGN_MASK;
            count_next = 3'd0;
            // Only a live stream needs an explicit abort before restarting.
            state_next = (state_reg == S_STREAM) ? S_STOP : S_START;
        end else begin
            count_next = count_reg + 3'(push) - pop_n;
            pc_next    = pc_reg + ADDR_BITS'({pop_n, 1'b0});
            case (state_reg)
                S_IDLE:  state_next = S_START;
                S_START: state_next = S_STREAM;
                S_STOP:  state_next = S_START;
                default: state_next = state_reg;
            endcase
        end
    end

    assign fetch_addr_next = pc_next + ADDR_BITS'({count_next, 1'b0});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= S_IDLE;
            pc_reg        <= PC_INIT;
            count_reg     <= 3'd0;
            mem_start_reg <= 1'b0;
            mem_stop_reg  <= 1'b0;
            mem_addr_reg  <= PC_INIT;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            count_reg     <= count_next;
            mem_start_reg <= (state_next == S_START);
            mem_stop_reg  <= (state_next == S_STOP);
            if (state_next == S_START) begin
                mem_addr_reg <= fetch_addr_next;
            end
        end
    end

    assign mem_start = mem_start_reg;
    assign mem_stop  = mem_stop_reg;
    assign mem_addr  = mem_addr_reg;
    assign pc        = pc_reg;
    assign instr     = {(count_reg >= 3'd2) ? fifo[1] : 16'h0000, fifo[0]};

endmodule

// File: tb/tb_tiny45_instr_fetch.sv
// Bench for tiny45_instr_fetch: sequential memory model feeding a halfword scoreboard
// that predicts instr/pc/instr_valid every cycle.
module tb_tiny45_instr_fetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic [23:0] mem_addr;
    logic        mem_start, mem_stop;
    logic [15:0] mem_data_in;
    logic        mem_data_valid, mem_data_ready;
    logic [31:0] instr;
    logic [23:0] pc;
    logic        instr_valid, instr_complete, branch;
    logic [23:0] branch_target;

    always #5 clk = ~clk;

    tiny45_instr_fetch #(.ADDR_BITS(24), .RESET_PC(24'h000100)) dut (
        .clk(clk), .rstn(rstn),
        .mem_addr(mem_addr), .mem_start(mem_start), .mem_stop(mem_stop),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
        .mem_data_ready(mem_data_ready),
        .instr(instr), .pc(pc), .instr_valid(instr_valid),
        .instr_complete(instr_complete), .branch(branch), .branch_target(branch_target)
    );

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
    } hw_t;

    int          n_vec = 0;
    int          n_bad = 0;
    hw_t         sb[$];
    logic [15:0] mem_aa [int unsigned];
    logic [23:0] exp_pc, mem_ptr;
    logic        mem_active;
    logic        c_start, c_stop, c_ready, c_valid, c_acc;
    logic [23:0] c_addr, c_pc;
    logic [31:0] c_instr;
    logic [15:0] c_data;
    int          n_acc = 0, n_stop = 0, n_start = 0;

    function automatic logic [15:0] hw(input logic [23:0] a);
        if (mem_aa.exists(32'(a))) return mem_aa[32'(a)];
        return {a[13:0], 2'b01};
    endfunction

    function automatic logic model_valid();
        if (sb.size() == 0) return 1'b0;
        if (sb[0].data[1:0] == 2'b11) return (sb.size() >= 2);
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_instr();
        if (sb.size() >= 2) return {sb[1].data, sb[0].data};
        return {16'h0000, sb[0].data};
    endfunction

    // One clock: drive core inputs, check at negedge, then advance memory and scoreboard.
    task automatic step(input logic cmp, input logic br, input logic [23:0] tgt);
        logic        exp_v;
        logic [31:0] exp_i;
        logic [23:0] exp_fa;
        int          pop;
        instr_complete = cmp;
        branch         = br;
        branch_target  = tgt;
        @(negedge clk);
        c_start = mem_start; c_stop = mem_stop; c_ready = mem_data_ready;
        c_valid = instr_valid; c_acc = mem_data_valid & mem_data_ready;
        c_addr = mem_addr; c_pc = pc; c_instr = instr; c_data = mem_data_in;
        exp_v = model_valid();
        n_vec++;
        if (instr_valid !== exp_v) begin
            n_bad++;
            $display("FAIL sb_valid: instr_valid=%b required %b (pc=%h)", instr_valid, exp_v, pc);
        end
        if (exp_v) begin
            exp_i = model_instr();
            n_vec++;
            if (instr !== exp_i || pc !== exp_pc) begin
                n_bad++;
                $display("FAIL sb_instr: instr=%h pc=%h required instr=%h pc=%h",
                         instr, pc, exp_i, exp_pc);
            end
        end
        if (br && c_acc) begin
            n_bad++;
            $display("FAIL branch_accept: mem_data_ready=1 in branch cycle, required 0");
        end
        if (sb.size() == 4) begin
            n_vec++;
            if (c_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL full_ready: mem_data_ready=%b required 0 with 4 entries", c_ready);
            end
        end
        if (c_start) begin
            n_start++;
            exp_fa = exp_pc + 24'(2 * sb.size());
            n_vec++;
            if (c_addr !== exp_fa) begin
                n_bad++;
                $display("FAIL start_addr: mem_addr=%h required %h", c_addr, exp_fa);
            end
        end
        if (c_stop) n_stop++;
        @(posedge clk);
        #1;
        if (br) begin
            sb.delete();
            exp_pc = {tgt[23:1], 1'b0};
        end else begin
            if (cmp && exp_v) begin
                pop = (sb[0].data[1:0] == 2'b11) ? 2 : 1;
                repeat (pop) void'(sb.pop_front());
                exp_pc = exp_pc + 24'(2 * pop);
            end
            if (c_acc) begin
                n_acc++;
                exp_fa = exp_pc + 24'(2 * sb.size());
                n_vec++;
                if (mem_ptr !== exp_fa) begin
                    n_bad++;
                    $display("FAIL push_addr: accepted halfword from %h required %h", mem_ptr, exp_fa);
                end
                sb.push_back({mem_ptr, c_data});
            end
        end
        if (c_acc) mem_ptr = mem_ptr + 24'd2;
        if (c_stop) mem_active = 1'b0;
        if (c_start) begin
            mem_active = 1'b1;
            mem_ptr    = c_addr;
        end
        mem_data_valid = mem_active;
        mem_data_in    = hw(mem_ptr);
        instr_complete = 1'b0;
        branch         = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        exp_pc         = 24'h000100;
        mem_active     = 1'b0;
        mem_ptr        = 24'h0;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (model_valid()) break;
            step(1'b0, 1'b0, 24'h0);
        end
        if (!model_valid()) begin
            n_bad++;
            $display("FAIL %s_timeout: no instruction within 20 cycles, required one", tag);
        end
    endtask

    task automatic test_reset();
        int i2, fv;
        mem_aa[32'h100] = 16'h0093;
        mem_aa[32'h102] = 16'h0010;
        rstn = 1'b0; instr_complete = 1'b0; branch = 1'b0; branch_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({mem_start, mem_stop, mem_data_ready, instr_valid} !== 4'b0000 || pc !== 24'h100) begin
            n_bad++;
            $display("FAIL reset_state: start/stop/ready/valid=%b%b%b%b pc=%h required 0000 pc=000100",
                     mem_start, mem_stop, mem_data_ready, instr_valid, pc);
        end
        rstn = 1'b1;
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: mem_start=%b in cycle 1, required 0", c_start);
        end
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_start !== 1'b1 || c_addr !== 24'h100) begin
            n_bad++;
            $display("FAIL reset_start: mem_start=%b mem_addr=%h in cycle 2, required 1 000100", c_start, c_addr);
        end
        i2 = -1; fv = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 24'h0);
            if (c_valid) begin
                fv = i;
                break;
            end
            if (c_acc && sb.size() == 2 && i2 < 0) i2 = i;
        end
        n_vec++;
        if (fv < 0 || fv != i2 + 1 || c_instr !== 32'h00100093 || c_pc !== 24'h100) begin
            n_bad++;
            $display("FAIL reset_first: valid@%0d instr=%h pc=%h required valid@%0d 00100093 000100",
                     fv, c_instr, c_pc, i2 + 1);
        end
        step(1'b1, 1'b0, 24'h0);
    endtask

    task automatic test_mixed();
        mem_aa[32'h100] = 16'h4501;
        mem_aa[32'h102] = 16'h0513;
        mem_aa[32'h104] = 16'h0000;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rstn = 1'b1;
        wait_valid("mixed1");
        step(1'b1, 1'b0, 24'h0);
        n_vec++;
        if (c_instr !== 32'h00004501 || c_pc !== 24'h100) begin
            n_bad++;
            $display("FAIL mixed_c: instr=%h pc=%h required 00004501 000100", c_instr, c_pc);
        end
        wait_valid("mixed2");
        step(1'b1, 1'b0, 24'h0);
        n_vec++;
        if (c_instr !== 32'h00000513 || c_pc !== 24'h102) begin
            n_bad++;
            $display("FAIL mixed_32: instr=%h pc=%h required 00000513 000102", c_instr, c_pc);
        end
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_pc !== 24'h106) begin
            n_bad++;
            $display("FAIL mixed_pc: pc=%h required 000106", c_pc);
        end
    endtask

    task automatic test_backpressure();
        int n0;
        mem_aa[32'h300] = 16'h0013;
        mem_aa[32'h302] = 16'h0000;
        step(1'b0, 1'b1, 24'h000300);
        n0 = n_acc;
        repeat (12) step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (n_acc - n0 != 4 || c_ready !== 1'b0 || c_instr !== 32'h00000013) begin
            n_bad++;
            $display("FAIL bp_full: accepts=%0d ready=%b instr=%h required 4 0 00000013",
                     n_acc - n0, c_ready, c_instr);
        end
        step(1'b1, 1'b0, 24'h0);
        repeat (6) step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (n_acc - n0 != 6 || c_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_resume: accepts=%0d ready=%b required 6 0", n_acc - n0, c_ready);
        end
    endtask

    task automatic test_branch();
        int s0;
        s0 = n_stop;
        step(1'b0, 1'b1, 24'h002002);
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_stop !== 1'b1 || c_start !== 1'b0) begin
            n_bad++;
            $display("FAIL br_stop: stop=%b start=%b required 1 0", c_stop, c_start);
        end
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_start !== 1'b1 || c_stop !== 1'b0 || c_addr !== 24'h002002) begin
            n_bad++;
            $display("FAIL br_start: start=%b stop=%b addr=%h required 1 0 002002", c_start, c_stop, c_addr);
        end
        wait_valid("br");
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_pc !== 24'h002002 || n_stop - s0 != 1) begin
            n_bad++;
            $display("FAIL br_pc: pc=%h stops=%0d required 002002 1", c_pc, n_stop - s0);
        end
    endtask

    task automatic test_branch_complete();
        step(1'b1, 1'b1, 24'h003000);
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_valid !== 1'b0 || c_pc !== 24'h003000) begin
            n_bad++;
            $display("FAIL brc_flush: valid=%b pc=%h required 0 003000", c_valid, c_pc);
        end
        wait_valid("brc");
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_pc !== 24'h003000 || c_instr[15:0] !== 16'hC001) begin
            n_bad++;
            $display("FAIL brc_target: pc=%h instr=%h required 003000 xxxxC001", c_pc, c_instr);
        end
    endtask

    task automatic test_back_to_back();
        int          s0, st0;
        logic [23:0] last_addr;
        s0 = n_stop;
        st0 = n_start;
        last_addr = '0;
        step(1'b0, 1'b1, 24'h000400);
        step(1'b0, 1'b1, 24'h000500);
        step(1'b0, 1'b1, 24'h000600);
        if (c_start) last_addr = c_addr;
        repeat (3) begin
            step(1'b0, 1'b0, 24'h0);
            if (c_start) last_addr = c_addr;
        end
        n_vec++;
        if (n_stop - s0 != 1 || n_start - st0 != 2 || last_addr !== 24'h000600) begin
            n_bad++;
            $display("FAIL b2b: stops=%0d starts=%0d last_addr=%h required 1 2 000600",
                     n_stop - s0, n_start - st0, last_addr);
        end
        wait_valid("b2b");
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_pc !== 24'h000600) begin
            n_bad++;
            $display("FAIL b2b_pc: pc=%h required 000600", c_pc);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 24'hFFFFFC);
        wait_valid("wrap1");
        step(1'b1, 1'b0, 24'h0);
        wait_valid("wrap2");
        step(1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_pc !== 24'h000000) begin
            n_bad++;
            $display("FAIL wrap_pc: pc=%h required 000000", c_pc);
        end
        wait_valid("wrap3");
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_valid !== 1'b1 || c_instr[15:0] !== 16'h0001) begin
            n_bad++;
            $display("FAIL wrap_fetch: valid=%b instr=%h required 1 xxxx0001", c_valid, c_instr);
        end
    endtask

    task automatic test_reset_midstream();
        repeat (3) step(1'b0, 1'b0, 24'h0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({mem_start, mem_stop, mem_data_ready, instr_valid} !== 4'b0000 || pc !== 24'h100) begin
            n_bad++;
            $display("FAIL rst_mid: start/stop/ready/valid=%b%b%b%b pc=%h required 0000 000100",
                     mem_start, mem_stop, mem_data_ready, instr_valid, pc);
        end
        model_reset();
        rstn = 1'b1;
        step(1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_start !== 1'b1 || c_addr !== 24'h100) begin
            n_bad++;
            $display("FAIL rst_mid_start: start=%b addr=%h required 1 000100", c_start, c_addr);
        end
        wait_valid("rstmid");
        step(1'b0, 1'b0, 24'h0);
        n_vec++;
        if (c_instr[15:0] !== 16'h4501 || c_pc !== 24'h100) begin
            n_bad++;
            $display("FAIL rst_mid_instr: instr=%h pc=%h required xxxx4501 000100", c_instr, c_pc);
        end
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_backpressure();
        test_branch();
        test_branch_complete();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
